fetch_unit: RTL and testbench



---
 rtl/processor_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit_pc.sv | 37 +++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/processor_pkg.sv
// Shared core definitions: word width, instruction width and fetch state encoding.
package processor_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int INSTR_WIDTH = WORD_SIZE;

  // Fetch state encoding; ERROR sits apart from the normal sequence.
  localparam logic [2:0] FETCH_START = 3'd0;
  localparam logic [2:0] FETCH_REQ   = 3'd1;
  localparam logic [2:0] FETCH_WAIT  = 3'd2;
  localparam logic [2:0] FETCH_VALID = 3'd3;
  localparam logic [2:0] FETCH_ERROR = 3'd7;

  typedef enum logic [2:0] {
    S_START = FETCH_START,
    S_REQ   = FETCH_REQ,
    S_WAIT  = FETCH_WAIT,
    S_VALID = FETCH_VALID,
    S_ERROR = FETCH_ERROR
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: RAM read port, execute redirect and decode handshake.
interface fetch_unit_if #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_rden;
  logic [WORD_SIZE-1:0]  mem_q;
  logic                  redirect_valid;
  logic [WORD_SIZE-1:0]  redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [WORD_SIZE-1:0]  instr;
  logic [WORD_SIZE-1:0]  instr_pc;
  logic                  fetch_error;

  // Fetch unit side.
  modport master (
    output mem_address, mem_rden, instr_valid, instr, instr_pc, fetch_error,
    input  mem_q, redirect_valid, redirect_pc, instr_ready
  );

  // Memory / execute / decode side.
  modport slave (
    input  mem_address, mem_rden, instr_valid, instr, instr_pc, fetch_error,
    output mem_q, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit_pc.sv
// Program counter with next-PC selection and fetch-address legality check.
module fetch_pc #(
  parameter int                   WORD_SIZE  = 32,
  parameter int                   ADDR_WIDTH = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_redirect,
  input  logic [WORD_SIZE-1:0] i_redirect_pc,
  input  logic                 i_advance,
  output logic [WORD_SIZE-1:0] o_pc,
  output logic                 o_pc_bad
);

  logic [WORD_SIZE-1:0] r_pc;
  logic                 w_misaligned;
  logic                 w_out_of_range;

  // PC update: reset, then redirect, then sequential +4, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst)
      r_pc <= RESET_PC;
    else if (i_redirect)
      r_pc <= i_redirect_pc;
    else if (i_advance)
      r_pc <= r_pc + WORD_SIZE'(4);
  end

  // Any bit above the RAM's byte-address span makes the PC unreachable.
  assign w_misaligned   = |r_pc[1:0];
  assign w_out_of_range = (r_pc >> (ADDR_WIDTH + 2)) != '0;

  assign o_pc     = r_pc;
  assign o_pc_bad = w_misaligned | w_out_of_range;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequences RAM reads and hands instructions to decode.
//
//  state | meaning
//  START | just out of reset, PC holds RESET_PC
//  REQ   | check PC, issue RAM read if legal
//  WAIT  | RAM data returning, capture it
//  VALID | instruction offered to decode
//  ERROR | illegal PC, halted until redirect
module fetch_unit #(
  parameter int                   WORD_SIZE  = processor_pkg::WORD_SIZE,
  parameter int                   ADDR_WIDTH = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  processor_pkg::fetch_state_e r_state, w_next_state;

  logic [WORD_SIZE-1:0] w_pc;
  logic                 w_pc_bad;
  logic                 w_redirect;
  logic                 w_advance;
  logic                 w_capture;
  logic                 w_req_ok;
  logic [WORD_SIZE-1:0] r_instr;
  logic [WORD_SIZE-1:0] r_instr_pc;

  // Redirects are ignored in START so the reset PC always gets one fetch slot.
  assign w_redirect = bus.redirect_valid && (r_state != processor_pkg::S_START);

  fetch_pc #(
    .WORD_SIZE  (WORD_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst           (rst),
    .i_redirect    (w_redirect),
    .i_redirect_pc (bus.redirect_pc),
    .i_advance     (w_advance),
    .o_pc          (w_pc),
    .o_pc_bad      (w_pc_bad)
  );

  // Next-state decode; a redirect beats everything, including ready.
  always_comb begin
    w_next_state = r_state;
    w_advance    = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      processor_pkg::S_START: w_next_state = processor_pkg::S_REQ;
      processor_pkg::S_REQ: begin
        if (w_redirect)    w_next_state = processor_pkg::S_REQ;
        else if (w_pc_bad) w_next_state = processor_pkg::S_ERROR;
        else               w_next_state = processor_pkg::S_WAIT;
      end
      processor_pkg::S_WAIT: begin
        if (w_redirect) begin
          w_next_state = processor_pkg::S_REQ;
        end else begin
          w_next_state = processor_pkg::S_VALID;
          w_capture    = 1'b1;
        end
      end
      processor_pkg::S_VALID: begin
        if (w_redirect) begin
          w_next_state = processor_pkg::S_REQ;
        end else if (bus.instr_ready) begin
          w_next_state = processor_pkg::S_REQ;
          w_advance    = 1'b1;
        end
      end
      processor_pkg::S_ERROR: begin
        if (w_redirect) w_next_state = processor_pkg::S_REQ;
      end
      default: w_next_state = processor_pkg::S_START;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= processor_pkg::S_START;
    else     r_state <= w_next_state;
  end

  // Capture returned instruction and its PC; held while decode stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else if (w_capture) begin
      r_instr    <= bus.mem_q;
      r_instr_pc <= w_pc;
    end
  end

  // Address is forced to zero outside a legal request so it reads 0 after reset.
  assign w_req_ok        = (r_state == processor_pkg::S_REQ) && !w_pc_bad;
  assign bus.mem_rden    = w_req_ok;
  assign bus.mem_address = w_req_ok ? w_pc[ADDR_WIDTH+1:2] : '0;
  assign bus.instr_valid = (r_state == processor_pkg::S_VALID);
  assign bus.fetch_error = (r_state == processor_pkg::S_ERROR);
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam int WS = 32;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  fetch_unit_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) bus ();

  fetch_unit #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    case (a)
      16'd0:   return 32'h0050_0093;
      16'd1:   return 32'h0010_0113;
      16'd2:   return 32'h0020_81B3;
      default: return ({16'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endcase
  endfunction

  function automatic logic pc_bad(input logic [31:0] p);
    return (p[1:0] != 2'b00) || ((p >> (AW + 2)) != 32'h0);
  endfunction

  // RAM: one-cycle read latency; junk on the bus when no read was issued.
  always @(posedge clk) begin
    if (bus.mem_rden) bus.mem_q <= ram_word(bus.mem_address);
    else              bus.mem_q <= $urandom;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.mem_rden !== 1'b0) $display("FAIL reset_rden got=%b exp=0", bus.mem_rden); else n_pass++;
    n_checks++;
    if (bus.mem_address !== 16'h0) $display("FAIL reset_addr got=%h exp=0", bus.mem_address); else n_pass++;
    n_checks++;
    if (bus.instr_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.instr_valid); else n_pass++;
    n_checks++;
    if (bus.instr !== 32'h0) $display("FAIL reset_instr got=%h exp=0", bus.instr); else n_pass++;
    n_checks++;
    if (bus.instr_pc !== 32'h0) $display("FAIL reset_instr_pc got=%h exp=0", bus.instr_pc); else n_pass++;
    n_checks++;
    if (bus.fetch_error !== 1'b0) $display("FAIL reset_error got=%b exp=0", bus.fetch_error); else n_pass++;
  endtask

  task automatic test_basic_fetch();
    int cyc_q[$];
    logic [31:0] pc_q[$];
    logic [31:0] ins_q[$];
    do_reset();
    bus.instr_ready = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) begin
        n_checks++;
        if (bus.mem_rden !== 1'b1 || bus.mem_address !== 16'h0)
          $display("FAIL basic_first_req got rden=%b addr=%h exp rden=1 addr=0", bus.mem_rden, bus.mem_address);
        else n_pass++;
      end
      if (bus.instr_valid) begin
        cyc_q.push_back(c);
        pc_q.push_back(bus.instr_pc);
        ins_q.push_back(bus.instr);
      end
    end
    n_checks++;
    if (cyc_q.size() != 3) $display("FAIL basic_count got=%0d exp=3", cyc_q.size()); else n_pass++;
    for (int k = 0; k < 3 && k < cyc_q.size(); k++) begin
      n_checks++;
      if (cyc_q[k] != 3 * (k + 1)) $display("FAIL basic_cycle[%0d] got=%0d exp=%0d", k, cyc_q[k], 3 * (k + 1));
      else n_pass++;
      n_checks++;
      if (pc_q[k] !== 32'(4 * k)) $display("FAIL basic_pc[%0d] got=%h exp=%h", k, pc_q[k], 32'(4 * k));
      else n_pass++;
      n_checks++;
      if (ins_q[k] !== ram_word(16'(k))) $display("FAIL basic_instr[%0d] got=%h exp=%h", k, ins_q[k], ram_word(16'(k)));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_instr, held_pc;
    int n;
    do_reset();
    n = 0;
    while (!bus.instr_valid && n < 10) begin tick(); n++; end
    n_checks++;
    if (!bus.instr_valid) $display("FAIL bp_valid_timeout got=0 exp=1"); else n_pass++;
    held_instr = ram_word(16'h0);
    held_pc    = 32'h0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== held_instr || bus.instr_pc !== held_pc || bus.mem_rden !== 1'b0)
        $display("FAIL bp_hold[%0d] got valid=%b instr=%h pc=%h rden=%b exp valid=1 instr=%h pc=%h rden=0",
                 c, bus.instr_valid, bus.instr, bus.instr_pc, bus.mem_rden, held_instr, held_pc);
      else n_pass++;
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    n_checks++;
    if (bus.mem_rden !== 1'b1 || bus.mem_address !== 16'h1)
      $display("FAIL bp_advance got rden=%b addr=%h exp rden=1 addr=1", bus.mem_rden, bus.mem_address);
    else n_pass++;
  endtask

  task automatic test_redirect_mid_fetch();
    int n, saw8;
    do_reset();
    bus.instr_ready = 1'b1;
    n = 0; saw8 = 0;
    while (!(bus.mem_rden && bus.mem_address == 16'h2) && n < 20) begin
      tick(); n++;
      if (bus.instr_valid && bus.instr_pc == 32'h8) saw8++;
    end
    n_checks++;
    if (n >= 20) $display("FAIL mid_req8_timeout got=none exp=req@2"); else n_pass++;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++;
    if (bus.mem_rden !== 1'b1 || bus.mem_address !== 16'h10)
      $display("FAIL mid_req40 got rden=%b addr=%h exp rden=1 addr=10", bus.mem_rden, bus.mem_address);
    else n_pass++;
    n = 0;
    while (!bus.instr_valid && n < 10) begin tick(); n++; end
    if (bus.instr_valid && bus.instr_pc == 32'h8) saw8++;
    n_checks++;
    if (bus.instr_pc !== 32'h40 || bus.instr !== ram_word(16'h10))
      $display("FAIL mid_next got pc=%h instr=%h exp pc=40 instr=%h", bus.instr_pc, bus.instr, ram_word(16'h10));
    else n_pass++;
    n_checks++;
    if (saw8 != 0) $display("FAIL mid_dropped got=%0d presentations of pc 8 exp=0", saw8); else n_pass++;
  endtask

  task automatic test_redirect_vs_ready();
    int n;
    do_reset();
    bus.instr_ready = 1'b1;
    n = 0;
    while (!(bus.instr_valid && bus.instr_pc == 32'h8) && n < 20) begin tick(); n++; end
    n_checks++;
    if (n >= 20) $display("FAIL rvr_timeout got=none exp=valid@8"); else n_pass++;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++;
    if (bus.mem_rden !== 1'b1 || bus.mem_address !== 16'h40)
      $display("FAIL rvr_addr got rden=%b addr=%h exp rden=1 addr=40", bus.mem_rden, bus.mem_address);
    else n_pass++;
  endtask

  task automatic check_bad_redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++;
    if (bus.mem_rden !== 1'b0 || bus.fetch_error !== 1'b0)
      $display("FAIL err_req[%h] got rden=%b err=%b exp rden=0 err=0", target, bus.mem_rden, bus.fetch_error);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (bus.fetch_error !== 1'b1 || bus.instr_valid !== 1'b0 || bus.mem_rden !== 1'b0)
        $display("FAIL err_hold[%h,%0d] got err=%b valid=%b rden=%b exp err=1 valid=0 rden=0",
                 target, c, bus.fetch_error, bus.instr_valid, bus.mem_rden);
      else n_pass++;
    end
  endtask

  task automatic test_errors();
    int n;
    bus.instr_ready = 1'b0;
    check_bad_redirect(32'h0000_0102);
    check_bad_redirect(32'h0004_0000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++;
    if (bus.mem_rden !== 1'b1 || bus.mem_address !== 16'h0 || bus.fetch_error !== 1'b0)
      $display("FAIL err_clear got rden=%b addr=%h err=%b exp rden=1 addr=0 err=0",
               bus.mem_rden, bus.mem_address, bus.fetch_error);
    else n_pass++;
    n = 0;
    while (!bus.instr_valid && n < 10) begin tick(); n++; end
    n_checks++;
    if (bus.instr_pc !== 32'h0 || bus.instr !== ram_word(16'h0))
      $display("FAIL err_refetch got pc=%h instr=%h exp pc=0 instr=%h", bus.instr_pc, bus.instr, ram_word(16'h0));
    else n_pass++;
    // Last legal word: stepping past it must land in ERROR.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0003_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    n = 0;
    while (!bus.instr_valid && n < 10) begin tick(); n++; end
    n_checks++;
    if (bus.instr_pc !== 32'h0003_FFFC || bus.instr !== ram_word(16'hFFFF))
      $display("FAIL top_word got pc=%h instr=%h exp pc=3fffc instr=%h", bus.instr_pc, bus.instr, ram_word(16'hFFFF));
    else n_pass++;
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    n_checks++;
    if (bus.mem_rden !== 1'b0) $display("FAIL top_wrap_rden got=%b exp=0", bus.mem_rden); else n_pass++;
    tick();
    n_checks++;
    if (bus.fetch_error !== 1'b1) $display("FAIL top_wrap_err got=%b exp=1", bus.fetch_error); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    bus.instr_ready = 1'b1;
    n = 0;
    while (!bus.mem_rden && n < 10) begin tick(); n++; end
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.mem_rden !== 1'b0 || bus.mem_address !== 16'h0 || bus.instr_valid !== 1'b0 ||
        bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 || bus.fetch_error !== 1'b0)
      $display("FAIL rst_mid_outputs got rden=%b addr=%h valid=%b instr=%h pc=%h err=%b exp all 0",
               bus.mem_rden, bus.mem_address, bus.instr_valid, bus.instr, bus.instr_pc, bus.fetch_error);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.mem_rden !== 1'b1 || bus.mem_address !== 16'h0)
      $display("FAIL rst_mid_refetch got rden=%b addr=%h exp rden=1 addr=0", bus.mem_rden, bus.mem_address);
    else n_pass++;
    n = 0;
    while (!bus.instr_valid && n < 10) begin tick(); n++; end
    n_checks++;
    if (bus.instr_pc !== 32'h0 || bus.instr !== ram_word(16'h0))
      $display("FAIL rst_mid_first got pc=%h instr=%h exp pc=0 instr=%h", bus.instr_pc, bus.instr, ram_word(16'h0));
    else n_pass++;
  endtask

  // Model: the fetch stream is the sequence of legal PCs starting at the last
  // redirect (or reset), stepping by 4 on each accepted instruction.
  task automatic test_random();
    logic [31:0] model_pc, target;
    logic        redir, rdy;
    int          gap, sel, errs;
    do_reset();
    model_pc = 32'h0;
    gap = 0;
    errs = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (bus.instr_valid) begin
        n_checks++;
        if (bus.instr_pc !== model_pc || bus.instr !== ram_word(model_pc[17:2])) begin
          if (errs++ < 10) $display("FAIL rnd_instr@%0d got pc=%h instr=%h exp pc=%h instr=%h",
                                    c, bus.instr_pc, bus.instr, model_pc, ram_word(model_pc[17:2]));
        end else n_pass++;
      end
      if (bus.mem_rden) begin
        n_checks++;
        if (pc_bad(model_pc) || bus.mem_address !== model_pc[17:2]) begin
          if (errs++ < 10) $display("FAIL rnd_req@%0d got addr=%h exp pc=%h legal", c, bus.mem_address, model_pc);
        end else n_pass++;
      end
      if (bus.fetch_error) begin
        n_checks++;
        if (!pc_bad(model_pc) || bus.instr_valid) begin
          if (errs++ < 10) $display("FAIL rnd_err@%0d got err with pc=%h valid=%b exp illegal pc, valid=0",
                                    c, model_pc, bus.instr_valid);
        end else n_pass++;
      end
      if (bus.instr_valid || bus.fetch_error) gap = 0; else gap++;
      n_checks++;
      if (gap > 2) begin
        if (errs++ < 10) $display("FAIL rnd_stall@%0d got gap=%0d exp<=2", c, gap);
      end else n_pass++;

      redir = ($urandom_range(0, 7) == 0);
      rdy   = 1'($urandom_range(0, 1));
      sel   = $urandom_range(0, 9);
      if (sel == 0)      target = {14'h0, 16'($urandom), 2'($urandom_range(1, 3))};
      else if (sel == 1) target = $urandom | 32'h0004_0000;
      else               target = {14'h0, 16'($urandom), 2'b00};
      bus.redirect_valid = redir;
      bus.redirect_pc    = target;
      bus.instr_ready    = rdy;
      if (redir) begin
        model_pc = target;
        gap = 0;
      end else if (bus.instr_valid && rdy) begin
        model_pc = model_pc + 32'd4;
      end
    end
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_mid_fetch();
    test_redirect_vs_ready();
    test_errors();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
